// File: rtl/timer_pkg.sv
// Shared types and constants for the system-timer alarm scheduler.
package timer_pkg;

    localparam int unsigned TIM_W = 64;

    typedef logic [TIM_W-1:0] tim_val_t;

    localparam logic TIM_MODE_ONESHOT  = 1'b0;
    localparam logic TIM_MODE_PERIODIC = 1'b1;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/timer_rr_arb.sv
// Combinational round-robin pick: first pending channel after last_grant, wrapping.
module timer_rr_arb
    import timer_pkg::*;
#(
    parameter  int unsigned NUM_CH = 4,
    localparam int unsigned CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] pend,
    input  logic [CH_W-1:0]   last_grant,
    output logic [CH_W-1:0]   grant_c,
    output logic              any_c
);

    logic [CH_W-1:0] idx;

    // Scan offsets 1..NUM_CH from last_grant; the lowest offset that is pending wins.
    always_comb begin
        grant_c = '0;
        any_c   = 1'b0;
        idx     = '0;
        for (int unsigned off = 1; off <= NUM_CH; off++) begin
            idx = CH_W'((32'(last_grant) + off) % NUM_CH);
            if (!any_c && pend[idx]) begin
                grant_c = idx;
                any_c   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_alarm_sched.sv
// Multi-channel compare/alarm scheduler presenting one pending channel at a time.
module timer_alarm_sched
    import timer_pkg::*;
#(
    parameter  int unsigned NUM_CH = 4,
    localparam int unsigned CH_W   = $clog2(NUM_CH)
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [TIM_W-1:0]  cnt_val,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [TIM_W-1:0]  cfg_cmp,
    input  logic [TIM_W-1:0]  cfg_period,
    input  logic              cfg_mode,
    input  logic              cfg_en,
    output logic              irq_valid,
    output logic [CH_W-1:0]   irq_ch,
    input  logic              irq_ack,
    output logic              tim_int,
    output logic [NUM_CH-1:0] armed,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] ovr
);

    arb_state_e        state_q, state_d;
    logic              irq_valid_q, irq_valid_d;
    logic [CH_W-1:0]   irq_ch_q, irq_ch_d;
    logic [CH_W-1:0]   last_grant_q, last_grant_d;
    // Presented channel has not been reconfigured since it was granted.
    logic              live_q, live_d;

    logic [NUM_CH-1:0] armed_q, armed_d;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] ovr_q, ovr_d;
    logic [NUM_CH-1:0] mode_q, mode_d;
    tim_val_t          cmp_q    [NUM_CH];
    tim_val_t          cmp_d    [NUM_CH];
    tim_val_t          period_q [NUM_CH];
    tim_val_t          period_d [NUM_CH];

    logic [NUM_CH-1:0] match_c;
    logic [NUM_CH-1:0] cfg_hit_c;
    logic [NUM_CH-1:0] ack_clr_c;
    logic              ack_c;
    logic [CH_W-1:0]   arb_grant_c;
    logic              arb_any_c;

    assign ack_c = (state_q == ST_PRESENT) && irq_ack;

    timer_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
        .pend       (pending_q),
        .last_grant (last_grant_q),
        .grant_c    (arb_grant_c),
        .any_c      (arb_any_c)
    );

    // Per-channel config, match, reload and pending/overrun bookkeeping.
    always_comb begin
        armed_d   = armed_q;
        pending_d = pending_q;
        ovr_d     = ovr_q;
        mode_d    = mode_q;
        cmp_d     = cmp_q;
        period_d  = period_q;
        match_c   = '0;
        cfg_hit_c = '0;
        ack_clr_c = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cfg_hit_c[i] = cfg_we && (cfg_ch == CH_W'(i));
            match_c[i]   = armed_q[i] && (cnt_val == cmp_q[i]);
            ack_clr_c[i] = ack_c && live_q && (irq_ch_q == CH_W'(i));
            if (cfg_hit_c[i]) begin
                // A write discards any match on the same edge.
                cmp_d[i]     = cfg_cmp;
                period_d[i]  = cfg_period;
                mode_d[i]    = cfg_mode;
                armed_d[i]   = cfg_en;
                pending_d[i] = 1'b0;
                ovr_d[i]     = 1'b0;
            end else begin
                if (ack_clr_c[i]) begin
                    pending_d[i] = 1'b0;
                end
                if (match_c[i]) begin
                    // A match beats a simultaneous ack and is not an overrun.
                    pending_d[i] = 1'b1;
                    if (pending_q[i] && !ack_clr_c[i]) begin
                        ovr_d[i] = 1'b1;
                    end
                    if ((mode_q[i] == TIM_MODE_PERIODIC) && (period_q[i] != '0)) begin
                        cmp_d[i] = cmp_q[i] + period_q[i];
                    end else begin
                        armed_d[i] = 1'b0;
                    end
                end
            end
        end
    end

    // Arbiter FSM next-state and presented-interrupt outputs.
    always_comb begin
        state_d      = state_q;
        irq_valid_d  = irq_valid_q;
        irq_ch_d     = irq_ch_q;
        last_grant_d = last_grant_q;
        live_d       = live_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_any_c) begin
                    irq_ch_d    = arb_grant_c;
                    irq_valid_d = 1'b1;
                    live_d      = !(cfg_we && (cfg_ch == arb_grant_c));
                    state_d     = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (cfg_we && (cfg_ch == irq_ch_q)) begin
                    live_d = 1'b0;
                end
                if (irq_ack) begin
                    irq_valid_d  = 1'b0;
                    last_grant_d = irq_ch_q;
                    live_d       = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; last_grant resets to the top channel so channel 0 wins first.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= ST_IDLE;
            irq_valid_q  <= 1'b0;
            irq_ch_q     <= '0;
            last_grant_q <= CH_W'(NUM_CH - 1);
            live_q       <= 1'b0;
            armed_q      <= '0;
            pending_q    <= '0;
            ovr_q        <= '0;
            mode_q       <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cmp_q[i]    <= '0;
                period_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            irq_valid_q  <= irq_valid_d;
            irq_ch_q     <= irq_ch_d;
            last_grant_q <= last_grant_d;
            live_q       <= live_d;
            armed_q      <= armed_d;
            pending_q    <= pending_d;
            ovr_q        <= ovr_d;
            mode_q       <= mode_d;
            cmp_q        <= cmp_d;
            period_q     <= period_d;
        end
    end

    assign irq_valid = irq_valid_q;
    assign irq_ch    = irq_ch_q;
    assign tim_int   = irq_valid_q;
    assign armed     = armed_q;
    assign pending   = pending_q;
    assign ovr       = ovr_q;

endmodule

// File: doc/timer_alarm_sched.md
# timer_alarm_sched

Multi-channel alarm scheduler for the 64-bit system timer. Holds NUM_CH independent compare channels, each in one-shot or periodic mode, and compares each one against the shared free-running counter. Matching channels latch a pending flag. A round-robin arbiter presents one pending channel at a time on a single interrupt line with a valid/ack handshake. It sits between the timer counter and the interrupt controller, replacing per-channel interrupt wiring.

## Interface
- NUM_CH, 4: number of compare channels, 2..16.
- CH_W, $clog2(NUM_CH): derived localparam, channel index width.

- sys_clk  in  1  clock; all state updates on rising edge
- sys_rst_n  in  1  reset; asynchronous, active-low
- cnt_val  in  64  free-running counter; advances by at most 1 per cycle
- cfg_we  in  1  single-cycle configuration write strobe
- cfg_ch  in  CH_W  channel index being written
- cfg_cmp  in  64  first match value
- cfg_period  in  64  reload increment (periodic mode)
- cfg_mode  in  1  0 = one-shot, 1 = periodic
- cfg_en  in  1  1 = arm channel, 0 = disarm
- irq_valid  out  1  a channel interrupt is being presented
- irq_ch  out  CH_W  channel being presented; stable while irq_valid
- irq_ack  in  1  consumer accepts the presented interrupt
- tim_int  out  1  equals irq_valid
- armed  out  NUM_CH  per-channel armed status
- pending  out  NUM_CH  per-channel pending status
- ovr  out  NUM_CH  sticky overrun: a match occurred while that channel was already pending

## Operation
- **Per-channel state:** armed, cmp[63:0], period[63:0], mode, pending, ovr.
- **Config write** (cfg_we=1): loads cmp, period and mode; sets armed=cfg_en; clears pending and ovr of cfg_ch.
- **Match:** armed && cnt_val==cmp, sampled at the clock edge. On a match:
  - Set pending. If pending was already set, set ovr.
  - Periodic with period≠0: cmp <= cmp+period, modulo 2^64 (wraps silently). Channel stays armed.
  - One-shot, or periodic with period==0: clear armed.
- **Config write vs. match, same channel, same cycle:** the write wins and the match is discarded.
- **Arbiter FSM:**
  - IDLE: if any pending bit is set, grant the first pending channel searching upward from last_grant+1 (wrapping). Register irq_ch, assert irq_valid, go to PRESENT.
  - PRESENT: hold irq_valid and irq_ch until irq_ack=1. On ack: clear pending[irq_ch], set last_grant=irq_ch, go to IDLE.
  - irq_ack while in IDLE is ignored.
- **Ack and match on the presented channel, same cycle:** set wins. pending stays 1 and ovr is not set.
- **Config write to the presented channel:** that channel's pending clears, but irq_valid is not retracted. A later ack clears nothing further.
- **Reset:** every output is 0. All channel registers are 0. last_grant = NUM_CH-1, so channel 0 has first priority. FSM starts in IDLE.

## Timing
- Match at edge N: pending is high after edge N. irq_valid is high after edge N+1 if the FSM was IDLE.
- Ack sampled at edge M: irq_valid is low after edge M. The next grant is presented after edge M+1 at the earliest. This guarantees at least one low cycle between interrupts.
- Config write at edge N: armed, cmp and pending reflect it after edge N. A match is possible from edge N+1 onward.
- Reset mid-handshake: irq_valid drops asynchronously. All pending and armed state is lost.

## Structure
- Shared package timer_pkg:
  - TIM_MODE_ONESHOT / TIM_MODE_PERIODIC constants.
  - Arbiter state encoding (ST_IDLE, ST_PRESENT).
  - 64-bit timer value typedef.
- Sub-module timer_rr_arb: combinational round-robin pick. Inputs: pending vector and last_grant. Outputs: grant index and any-valid.
- Channel registers and FSM live in timer_alarm_sched.

## Test plan
- **One-shot:** ch1 cmp=100, cnt_val ramps from 90 → pending[1] high after cnt_val=100 edge; irq_valid=1, irq_ch=1 one cycle later; armed[1]=0. Ack → pending[1]=0, no second interrupt at 101.
- **Periodic with wrap:** ch0 cmp=2^64-3, period=5 → matches at 2^64-3 and at 2 after wrap; cmp becomes 7.
- **Round-robin fairness:** ch0, ch2 and ch3 all match on the same edge → presented order 0, 2, 3 with one idle cycle between each. Re-pend ch0 and ch2 → order 0, 2 (search restarts from last_grant+1=0).
- **Overrun:** ch2 periodic, period=4, ack withheld → second match sets ovr[2]=1 and pending stays 1. Config write to ch2 → ovr[2]=0.
- **Collisions:**
  - cfg_we to ch1 on its match edge → no pending.
  - Ack of ch1 on a cycle when ch1 re-matches → pending[1] stays 1 and ch1 is re-presented.
- **Async reset during PRESENT:** irq_valid, pending and armed drop to 0 immediately. After release, channel 0 is granted first.
